// File: rtl/draw_command_queue_if.sv
// draw_command_queue_if: producer command channel plus the DrawMif issue channel.
// slave = the queue itself, master = the surrounding logic (producer + DrawMif).
interface draw_command_queue_if;
  logic        cmdValid;
  logic [15:0] cmdX;
  logic [15:0] cmdY;
  logic [7:0]  cmdMifId;
  logic        cmdReady;
  logic [15:0] xOrigin;
  logic [15:0] yOrigin;
  logic [7:0]  mifId;
  logic        draw;
  logic        ready;

  modport slave (
    input  cmdValid, cmdX, cmdY, cmdMifId, ready,
    output cmdReady, xOrigin, yOrigin, mifId, draw
  );

  modport master (
    output cmdValid, cmdX, cmdY, cmdMifId, ready,
    input  cmdReady, xOrigin, yOrigin, mifId, draw
  );
endinterface

// File: rtl/draw_command_queue.sv
// draw_command_queue: FIFO of sprite draw commands feeding DrawMif one at a time.
// Optional feature macro DRAW_QUEUE_STATS_EN adds issuedCount/droppedCount.
module draw_command_queue #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 320,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  draw_command_queue_if.slave  bus,
  input  logic                 flush,
  output logic [ADDR_W:0]      queueCount,
  output logic                 busy,
  output logic                 overflow,
  output logic                 reject,
  output logic                 ackError
`ifdef DRAW_QUEUE_STATS_EN
  ,
  output logic [15:0]          issuedCount,
  output logic [15:0]          droppedCount
`endif
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  id;
  } cmd_t;

  cmd_t              mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              cmd_ready_q, cmd_ready_d;
  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  cmd_t              out_q, out_d;
  logic              draw_q, draw_d;
  logic              overflow_q, overflow_d;
  logic              reject_q, reject_d;
  logic              ack_error_q, ack_error_d;

  logic              in_bounds;
  logic              push;
  logic              issue;
  cmd_t              wr_cmd;
  cmd_t              head;

  assign wr_cmd    = {bus.cmdX, bus.cmdY, bus.cmdMifId};
  assign head      = mem_q[rd_ptr_q];
  assign in_bounds = (bus.cmdX < 16'(WIDTH)) && (bus.cmdY < 16'(HEIGHT));

  // Queue pointers, occupancy and drop pulses; flush wins over push/pop bookkeeping.
  always_comb begin
    push       = bus.cmdValid && cmd_ready_q && in_bounds && !flush;
    overflow_d = bus.cmdValid && !cmd_ready_q && in_bounds && !flush;
    reject_d   = bus.cmdValid && !in_bounds;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (issue) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, issue})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    cmd_ready_d = (count_d != (ADDR_W + 1)'(DEPTH));
  end

  // Issue FSM: one outstanding draw, handshake on ready falling then rising.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    out_d       = out_q;
    draw_d      = 1'b0;
    ack_error_d = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && bus.ready) begin
          issue   = 1'b1;
          out_d   = head;
          draw_d  = 1'b1;
          timer_d = TMR_W'(1);
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!bus.ready) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
          ack_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= '0;
      out_q       <= '0;
      draw_q      <= 1'b0;
      overflow_q  <= 1'b0;
      reject_q    <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      out_q       <= out_d;
      draw_q      <= draw_d;
      overflow_q  <= overflow_d;
      reject_q    <= reject_d;
      ack_error_q <= ack_error_d;
    end
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_cmd;
    end
  end

`ifdef DRAW_QUEUE_STATS_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] dropped_q, dropped_d;

  // Saturating activity counters; only reset clears them.
  always_comb begin
    issued_d  = issued_q;
    dropped_d = dropped_q;
    if (issue && issued_q != '1) begin
      issued_d = issued_q + 1'b1;
    end
    if ((overflow_d || reject_d) && dropped_q != '1) begin
      dropped_d = dropped_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
    end
  end

  assign issuedCount  = issued_q;
  assign droppedCount = dropped_q;
`endif

  // cmdReady resets high internally but reads low while reset is held.
  assign bus.cmdReady = cmd_ready_q && !reset;
  assign bus.xOrigin  = out_q.x;
  assign bus.yOrigin  = out_q.y;
  assign bus.mifId    = out_q.id;
  assign bus.draw     = draw_q;
  assign queueCount   = count_q;
  assign busy         = (state_q != IDLE);
  assign overflow     = overflow_q;
  assign reject       = reject_q;
  assign ackError     = ack_error_q;

endmodule

// File: tb/tb_draw_command_queue.sv
// tb_draw_command_queue: directed stimulus with a draw-payload scoreboard and
// a simple DrawMif responder model.
module tb_draw_command_queue;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [3:0] queue_count;
  logic       busy;
  logic       overflow;
  logic       reject;
  logic       ack_error;
`ifdef DRAW_QUEUE_STATS_EN
  logic [15:0] issued_count;
  logic [15:0] dropped_count;
`endif

  draw_command_queue_if bus ();

  draw_command_queue #(
    .DEPTH(8),
    .ADDR_W(3),
    .WIDTH(240),
    .HEIGHT(320),
    .ACK_TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .flush(flush),
    .queueCount(queue_count),
    .busy(busy),
    .overflow(overflow),
    .reject(reject),
    .ackError(ack_error)
`ifdef DRAW_QUEUE_STATS_EN
    ,
    .issuedCount(issued_count),
    .droppedCount(dropped_count)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [39:0] sb[$];
  int draw_cnt = 0, ovf_cnt = 0, rej_cnt = 0, ack_cnt = 0;
  int draw_cyc = 0, ack_cyc = 0, push_cyc = 0;
  logic [39:0] ref_out = '0;
  bit have_ref = 0;
  bit auto_mode = 0;
  int busy_left = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push_cmd(input logic [15:0] x, input logic [15:0] y, input logic [7:0] id, input bit stored);
    bus.cmdValid = 1'b1;
    bus.cmdX     = x;
    bus.cmdY     = y;
    bus.cmdMifId = id;
    push_cyc     = cyc;
    if (stored) sb.push_back({x, y, id});
    tick();
    bus.cmdValid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0 && !busy && queue_count == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    check(name, done, 1);
  endtask

  task automatic wait_draw(input string name, input int max_cycles);
    int start = draw_cnt;
    bit seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (draw_cnt != start) begin
        seen = 1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  // Monitor: pops the scoreboard on each draw pulse, checks the origin stays held while busy.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        have_ref = 0;
      end else begin
        if (overflow)  ovf_cnt++;
        if (reject)    rej_cnt++;
        if (ack_error) begin
          ack_cnt++;
          ack_cyc = cyc;
        end
        if (bus.draw) begin
          draw_cnt++;
          draw_cyc = cyc;
          check("draw_expected", sb.size() > 0, 1);
          if (sb.size() > 0) check("draw_payload", {bus.xOrigin, bus.yOrigin, bus.mifId}, sb.pop_front());
          ref_out  = {bus.xOrigin, bus.yOrigin, bus.mifId};
          have_ref = 1;
        end else if (busy && have_ref) begin
          check("origin_hold", {bus.xOrigin, bus.yOrigin, bus.mifId}, ref_out);
        end
      end
    end
  end

  // DrawMif model: drops ready after a draw, stays busy a few cycles.
  initial begin
    forever begin
      @(negedge clock);
      if (auto_mode) begin
        if (bus.draw) begin
          bus.ready = 1'b0;
          busy_left = 3;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) bus.ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, r0, a0, d1, a1, d2;
    reset        = 1'b1;
    flush        = 1'b0;
    bus.cmdValid = 1'b0;
    bus.cmdX     = '0;
    bus.cmdY     = '0;
    bus.cmdMifId = '0;
    bus.ready    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_cmd_ready", bus.cmdReady, 1);
    check("rst_count", queue_count, 0);
    check("rst_busy", busy, 0);
    check("rst_draw", bus.draw, 0);
    check("rst_pulses", {overflow, reject, ack_error}, 0);
    check("rst_origin", {bus.xOrigin, bus.yOrigin, bus.mifId}, 0);

    // Single command latency and hold
    busy_left = 0;
    bus.ready = 1'b1;
    auto_mode = 1;
    d0 = draw_cnt;
    push_cmd(16'd10, 16'd20, 8'd3, 1);
    wait_drain("drain_single", 50);
    check("latency", draw_cyc - push_cyc, 2);
    check("single_draws", draw_cnt - d0, 1);
    check("hold_after_done", {bus.xOrigin, bus.yOrigin, bus.mifId}, {16'd10, 16'd20, 8'd3});

    // Fill to overflow with DrawMif not ready
    auto_mode = 0;
    bus.ready = 1'b0;
    tick();
    d0 = draw_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) check("ready_before_8th", bus.cmdReady, 1);
      if (i == 8) check("ready_low_after_8th", bus.cmdReady, 0);
      push_cmd(16'(i * 10 + 1), 16'(i * 5 + 2), 8'(i + 40), i < 8);
    end
    repeat (2) tick();
    check("overflow_once", ovf_cnt - o0, 1);
    check("full_count", queue_count, 8);
    check("no_draw_while_not_ready", draw_cnt - d0, 0);
    busy_left = 0;
    bus.ready = 1'b1;
    auto_mode = 1;
    wait_drain("drain_full", 300);
    check("full_draws", draw_cnt - d0, 8);
    check("ready_after_drain", bus.cmdReady, 1);

    // Off-screen rejection and in-bounds corner
    d0 = draw_cnt;
    r0 = rej_cnt;
    o0 = ovf_cnt;
    push_cmd(16'd240, 16'd0, 8'd5, 0);
    push_cmd(16'd0, 16'd320, 8'd6, 0);
    repeat (3) tick();
    check("reject_twice", rej_cnt - r0, 2);
    check("reject_count", queue_count, 0);
    check("reject_no_draw", draw_cnt - d0, 0);
    check("reject_no_overflow", ovf_cnt - o0, 0);
    push_cmd(16'd239, 16'd319, 8'd7, 1);
    wait_drain("drain_corner", 50);
    check("corner_draws", draw_cnt - d0, 1);

    // Ack timeout: ready stuck high
    auto_mode = 0;
    bus.ready = 1'b0;
    tick();
    a0 = ack_cnt;
    push_cmd(16'd100, 16'd100, 8'd1, 1);
    push_cmd(16'd50, 16'd60, 8'd2, 1);
    bus.ready = 1'b1;
    wait_draw("timeout_first_draw", 10);
    d1 = draw_cyc;
    for (int i = 0; i < 40 && ack_cnt == a0; i++) tick();
    check("ack_error_seen", ack_cnt - a0, 1);
    a1 = ack_cyc;
    check("ack_error_timing", a1 - d1, 16);
    wait_draw("timeout_second_draw", 10);
    d2 = draw_cyc;
    check("reissue_after_timeout", d2 - a1, 1);
    wait_drain("drain_timeout", 60);
    check("ack_error_total", ack_cnt - a0, 2);

    // Flush while first entry is in WAIT_DONE
    bus.ready = 1'b0;
    tick();
    d0 = draw_cnt;
    push_cmd(16'd11, 16'd12, 8'd1, 1);
    push_cmd(16'd13, 16'd14, 8'd2, 0);
    push_cmd(16'd15, 16'd16, 8'd3, 0);
    push_cmd(16'd17, 16'd18, 8'd4, 0);
    bus.ready = 1'b1;
    wait_draw("flush_first_draw", 10);
    bus.ready = 1'b0;
    tick();
    check("flush_pre_count", queue_count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", queue_count, 0);
    check("flush_inflight_busy", busy, 1);
    bus.ready = 1'b1;
    repeat (10) tick();
    check("flush_done_idle", busy, 0);
    check("flush_no_more_draws", draw_cnt - d0, 1);

    // Reset in WAIT_DONE with 3 queued
    bus.ready = 1'b0;
    tick();
    d0 = draw_cnt;
    push_cmd(16'd21, 16'd22, 8'd9, 1);
    push_cmd(16'd23, 16'd24, 8'd8, 0);
    push_cmd(16'd25, 16'd26, 8'd7, 0);
    push_cmd(16'd27, 16'd28, 8'd6, 0);
    bus.ready = 1'b1;
    wait_draw("reset_first_draw", 10);
    bus.ready = 1'b0;
    tick();
    check("reset_pre_count", queue_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("reset_mid_draw", bus.draw, 0);
    check("reset_mid_busy", busy, 0);
    check("reset_mid_count", queue_count, 0);
    check("reset_mid_cmd_ready", bus.cmdReady, 1);
`ifdef DRAW_QUEUE_STATS_EN
    check("reset_mid_issued", issued_count, 0);
`endif
    bus.ready = 1'b1;
    repeat (6) tick();
    check("reset_no_more_draws", draw_cnt - d0, 1);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
